// File: rtl/dsi_lp_pkg.sv
// Shared types and constants for the DSI LP escape-mode receive path.
// Line states, escape-entry sequence, entry commands and decoder states.
package dsi_lp_pkg;

    typedef enum logic [1:0] {
        LP00 = 2'b00,
        LP01 = 2'b01,
        LP10 = 2'b10,
        LP11 = 2'b11
    } lp_line_t;

    // Escape entry after leaving LP-11: 10, 00, 01, 00 (first step in the top bits)
    localparam logic [7:0] ESC_ENTRY_SEQ  = 8'b10_00_01_00;

    localparam logic [7:0] LPDT_CMD       = 8'b11100001;
    localparam logic [7:0] ULPS_CMD       = 8'b00011110;
    localparam logic [7:0] TRIG_RESET_CMD = 8'b01100010;

    typedef enum logic [2:0] {
        DISABLED,
        STOP,
        ENT_10,
        ENT_00,
        ENT_01,
        CMD,
        LPDT,
        WAIT_STOP
    } rx_state_t;

    function automatic lp_line_t esc_step(input logic [1:0] idx);
        case (idx)
            2'd0:    return lp_line_t'(ESC_ENTRY_SEQ[7:6]);
            2'd1:    return lp_line_t'(ESC_ENTRY_SEQ[5:4]);
            2'd2:    return lp_line_t'(ESC_ENTRY_SEQ[3:2]);
            default: return lp_line_t'(ESC_ENTRY_SEQ[1:0]);
        endcase
    endfunction

endpackage

// File: rtl/dsi_lp_line_sync.sv
// LP line pair synchronizer (2 flops) plus optional glitch filter (DSI_LP_RX_FILTER_EN,
// +FILTER_LEN cycles); emits line state, previous state and a change pulse. No backpressure.
module dsi_lp_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       lp_p_in,
    input  logic       lp_n_in,
    output logic [1:0] l,
    output logic [1:0] l_prev,
    output logic       l_changed
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        dsi_lp_filter_len_out_of_range u_bad ();
    end

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] l_prev_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {lp_p_in, lp_n_in};
            sync2_q <= sync1_q;
        end
    end

`ifdef DSI_LP_RX_FILTER_EN
    logic [1:0] cand_q;
    logic [3:0] run_q;
    logic [1:0] l_filt_q;

    // run_q counts consecutive samples equal to cand_q; accept on the FILTER_LEN-th
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= 2'b11;
            run_q    <= 4'd0;
            l_filt_q <= 2'b11;
        end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            run_q  <= 4'd1;
        end else begin
            if (run_q != 4'(FILTER_LEN))
                run_q <= run_q + 4'd1;
            if (run_q == 4'(FILTER_LEN - 1))
                l_filt_q <= cand_q;
        end
    end

    assign l = l_filt_q;
`else
    assign l = sync2_q;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            l_prev_q <= 2'b11;
        else
            l_prev_q <= l;
    end

    assign l_prev    = l_prev_q;
    assign l_changed = (l != l_prev_q);

endmodule

// File: rtl/dsi_lp_esc_rx_lane.sv
// DSI lane-0 LP escape receiver: entry, command, LPDT bytes (MSB-first), stop; filter via DSI_LP_RX_FILTER_EN.
// Strobes 1 cycle after the decoded line event (sync 2 cycles ahead); no backpressure, consumer takes every strobe.
module dsi_lp_esc_rx_lane
    import dsi_lp_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       lp_p_in,
    input  logic       lp_n_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_valid,
    output logic       rx_active,
    output logic       rx_hs_rqst,
    output logic       err_esc,
    output logic       err_sync,
    output logic       err_ctrl
);

    logic [1:0] l;
    logic [1:0] l_prev;
    logic       l_changed;

    rx_state_t  state_q, state_nxt;
    logic [7:0] shift_q;
    logic [2:0] cnt_q;

    logic       bit_evt, bit_val, ctrl_evt, stop_evt, byte_done, clean_stop, in_bits;
    logic [7:0] byte_val;
    logic       vld_nxt, cmd_vld_nxt, hs_nxt, esc_nxt, sync_nxt, ctrl_nxt;

    dsi_lp_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .lp_p_in   (lp_p_in),
        .lp_n_in   (lp_n_in),
        .l         (l),
        .l_prev    (l_prev),
        .l_changed (l_changed)
    );

    assign bit_evt    = l_changed && (l_prev == LP00) && (l == LP10 || l == LP01);
    assign bit_val    = (l == LP10);
    assign ctrl_evt   = l_changed && ((l_prev == LP10 && l == LP01) || (l_prev == LP01 && l == LP10));
    assign stop_evt   = l_changed && (l == LP11);
    assign byte_val   = {shift_q[6:0], bit_val};
    assign byte_done  = bit_evt && (cnt_q == 3'd7);
    // Stop right after a whole byte, or after the trailing mark-one bit, is a clean end of LPDT
    assign clean_stop = (l_prev != LP01) && ((cnt_q == 3'd0) || (cnt_q == 3'd1 && shift_q[0]));
    assign in_bits    = (state_q == CMD) || (state_q == LPDT);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            state_q <= DISABLED;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (!enable) begin
            state_nxt = DISABLED;
        end else begin
            case (state_q)
                DISABLED:  if (l == LP11) state_nxt = STOP;
                STOP: begin
                    if (l_changed && l == esc_step(2'd0)) state_nxt = ENT_10;
                    else if (l_changed && l == LP01)      state_nxt = WAIT_STOP;
                end
                ENT_10:    if (l_changed) state_nxt = (l == esc_step(2'd1)) ? ENT_00 : (l == LP11) ? STOP : WAIT_STOP;
                ENT_00:    if (l_changed) state_nxt = (l == esc_step(2'd2)) ? ENT_01 : (l == LP11) ? STOP : WAIT_STOP;
                ENT_01:    if (l_changed) state_nxt = (l == esc_step(2'd3)) ? CMD    : (l == LP11) ? STOP : WAIT_STOP;
                CMD: begin
                    if (stop_evt)       state_nxt = STOP;
                    else if (ctrl_evt)  state_nxt = WAIT_STOP;
                    else if (byte_done) state_nxt = (byte_val == LPDT_CMD) ? LPDT : WAIT_STOP;
                end
                LPDT: begin
                    if (stop_evt)      state_nxt = STOP;
                    else if (ctrl_evt) state_nxt = WAIT_STOP;
                end
                WAIT_STOP: if (stop_evt) state_nxt = STOP;
                default:   state_nxt = DISABLED;
            endcase
        end
    end

    always_comb begin
        vld_nxt     = 1'b0;
        cmd_vld_nxt = 1'b0;
        hs_nxt      = 1'b0;
        esc_nxt     = 1'b0;
        sync_nxt    = 1'b0;
        ctrl_nxt    = 1'b0;
        rx_active   = (state_q == LPDT);
        if (enable) begin
            case (state_q)
                STOP:   hs_nxt  = l_changed && (l == LP01);
                ENT_10: esc_nxt = l_changed && (l != esc_step(2'd1)) && (l != LP11);
                ENT_00: esc_nxt = l_changed && (l != esc_step(2'd2)) && (l != LP11);
                ENT_01: esc_nxt = l_changed && (l != esc_step(2'd3)) && (l != LP11);
                CMD: begin
                    sync_nxt    = stop_evt;
                    ctrl_nxt    = ctrl_evt;
                    cmd_vld_nxt = byte_done && (byte_val != LPDT_CMD);
                end
                LPDT: begin
                    sync_nxt = stop_evt && !clean_stop;
                    ctrl_nxt = ctrl_evt;
                    vld_nxt  = byte_done;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= 8'd0;
            cnt_q        <= 3'd0;
            rx_data      <= 8'd0;
            rx_cmd       <= 8'd0;
            rx_valid     <= 1'b0;
            rx_cmd_valid <= 1'b0;
            rx_hs_rqst   <= 1'b0;
            err_esc      <= 1'b0;
            err_sync     <= 1'b0;
            err_ctrl     <= 1'b0;
        end else begin
            rx_valid     <= vld_nxt;
            rx_cmd_valid <= cmd_vld_nxt;
            rx_hs_rqst   <= hs_nxt;
            err_esc      <= esc_nxt;
            err_sync     <= sync_nxt;
            err_ctrl     <= ctrl_nxt;
            if (vld_nxt)
                rx_data <= byte_val;
            if (cmd_vld_nxt)
                rx_cmd <= byte_val;
            // Any exit from bit decoding drops the partial byte
            if (state_nxt != CMD && state_nxt != LPDT) begin
                shift_q <= 8'd0;
                cnt_q   <= 3'd0;
            end else if (in_bits && bit_evt) begin
                shift_q <= byte_val;
                cnt_q   <= cnt_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dsi_lp_esc_rx_lane.sv
// Directed bench for dsi_lp_esc_rx_lane: drives LP line sequences and checks strobes/data.
module tb_dsi_lp_esc_rx_lane;

    localparam int HOLD = 6;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       lp_p_in = 1'b1;
    logic       lp_n_in = 1'b1;
    logic [7:0] rx_data, rx_cmd;
    logic       rx_valid, rx_cmd_valid, rx_active, rx_hs_rqst, err_esc, err_sync, err_ctrl;

    int compared   = 0;
    int mismatched = 0;

    int n_vld = 0, n_cmd = 0, n_hs = 0, n_esc = 0, n_sync = 0, n_ctrl = 0, n_act = 0;
    int b_vld, b_cmd, b_hs, b_esc, b_sync, b_ctrl, b_act, b_log;
    logic [7:0] data_log[$];
    logic [7:0] last_cmd = 8'd0;

    always #5 clk_sys = ~clk_sys;

    dsi_lp_esc_rx_lane #(.FILTER_LEN(3)) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .enable       (enable),
        .lp_p_in      (lp_p_in),
        .lp_n_in      (lp_n_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_cmd       (rx_cmd),
        .rx_cmd_valid (rx_cmd_valid),
        .rx_active    (rx_active),
        .rx_hs_rqst   (rx_hs_rqst),
        .err_esc      (err_esc),
        .err_sync     (err_sync),
        .err_ctrl     (err_ctrl)
    );

    always @(negedge clk_sys) begin
        if (rx_valid) begin
            n_vld++;
            data_log.push_back(rx_data);
        end
        if (rx_cmd_valid) begin
            n_cmd++;
            last_cmd = rx_cmd;
        end
        if (rx_hs_rqst) n_hs++;
        if (err_esc)    n_esc++;
        if (err_sync)   n_sync++;
        if (err_ctrl)   n_ctrl++;
        if (rx_active)  n_act++;
    end

    task automatic line(input logic [1:0] l, input int cycles);
        @(negedge clk_sys);
        {lp_p_in, lp_n_in} = l;
        repeat (cycles) @(negedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        line(b ? 2'b10 : 2'b01, HOLD);
        line(2'b00, HOLD);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_entry();
        line(2'b10, HOLD);
        line(2'b00, HOLD);
        line(2'b01, HOLD);
        line(2'b00, HOLD);
    endtask

    task automatic snap();
        b_vld = n_vld; b_cmd = n_cmd; b_hs = n_hs; b_esc = n_esc;
        b_sync = n_sync; b_ctrl = n_ctrl; b_act = n_act; b_log = data_log.size();
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data: got %0h want 00", rx_data); end
        compared++; if (rx_cmd !== 8'h00) begin mismatched++; $display("FAIL reset_rx_cmd: got %0h want 00", rx_cmd); end
        outs = {1'b0, rx_valid, rx_cmd_valid, rx_active, rx_hs_rqst, err_esc, err_sync, err_ctrl};
        compared++; if (outs !== 8'h00) begin mismatched++; $display("FAIL reset_strobes: got %b want 00000000", outs); end
        rst_n  = 1'b1;
        enable = 1'b1;
        line(2'b11, HOLD);
        outs = {1'b0, rx_valid, rx_cmd_valid, rx_active, rx_hs_rqst, err_esc, err_sync, err_ctrl};
        compared++; if (outs !== 8'h00) begin mismatched++; $display("FAIL idle_strobes: got %b want 00000000", outs); end
    endtask

    task automatic test_lpdt();
        snap();
        send_entry();
        send_byte(8'hE1);
        compared++; if (rx_active !== 1'b1) begin mismatched++; $display("FAIL lpdt_active_after_cmd: got %b want 1", rx_active); end
        send_byte(8'hA5);
        compared++; if (rx_active !== 1'b1) begin mismatched++; $display("FAIL lpdt_active_mid: got %b want 1", rx_active); end
        send_byte(8'h3C);
        line(2'b10, HOLD);
        line(2'b11, HOLD);
        compared++; if (n_vld - b_vld !== 2) begin mismatched++; $display("FAIL lpdt_vld_count: got %0d want 2", n_vld - b_vld); end
        compared++; if (data_log[b_log] !== 8'hA5) begin mismatched++; $display("FAIL lpdt_byte0: got %0h want a5", data_log[b_log]); end
        compared++; if (data_log[b_log+1] !== 8'h3C) begin mismatched++; $display("FAIL lpdt_byte1: got %0h want 3c", data_log[b_log+1]); end
        compared++; if (rx_data !== 8'h3C) begin mismatched++; $display("FAIL lpdt_rx_data_held: got %0h want 3c", rx_data); end
        compared++; if ((n_sync - b_sync) + (n_ctrl - b_ctrl) + (n_esc - b_esc) !== 0) begin
            mismatched++; $display("FAIL lpdt_errors: got %0d want 0", (n_sync - b_sync) + (n_ctrl - b_ctrl) + (n_esc - b_esc)); end
        compared++; if (n_cmd - b_cmd !== 0) begin mismatched++; $display("FAIL lpdt_cmd_count: got %0d want 0", n_cmd - b_cmd); end
        compared++; if (rx_active !== 1'b0) begin mismatched++; $display("FAIL lpdt_active_after_stop: got %b want 0", rx_active); end
    endtask

    task automatic test_ulps();
        snap();
        send_entry();
        send_byte(8'h1E);
        line(2'b11, HOLD);
        compared++; if (n_cmd - b_cmd !== 1) begin mismatched++; $display("FAIL ulps_cmd_count: got %0d want 1", n_cmd - b_cmd); end
        compared++; if (last_cmd !== 8'h1E) begin mismatched++; $display("FAIL ulps_cmd_value: got %0h want 1e", last_cmd); end
        compared++; if (rx_cmd !== 8'h1E) begin mismatched++; $display("FAIL ulps_rx_cmd_held: got %0h want 1e", rx_cmd); end
        compared++; if (n_act - b_act !== 0) begin mismatched++; $display("FAIL ulps_active_cycles: got %0d want 0", n_act - b_act); end
        compared++; if (n_vld - b_vld !== 0) begin mismatched++; $display("FAIL ulps_vld_count: got %0d want 0", n_vld - b_vld); end
        compared++; if (n_sync - b_sync !== 0) begin mismatched++; $display("FAIL ulps_err_sync: got %0d want 0", n_sync - b_sync); end
    endtask

    task automatic test_sync_err();
        snap();
        send_entry();
        send_byte(8'hE1);
        send_byte(8'hFF);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        line(2'b11, HOLD);
        compared++; if (n_vld - b_vld !== 1) begin mismatched++; $display("FAIL sync_vld_count: got %0d want 1", n_vld - b_vld); end
        compared++; if (data_log[b_log] !== 8'hFF) begin mismatched++; $display("FAIL sync_byte: got %0h want ff", data_log[b_log]); end
        compared++; if (n_sync - b_sync !== 1) begin mismatched++; $display("FAIL sync_err_count: got %0d want 1", n_sync - b_sync); end
    endtask

    task automatic test_esc_err();
        snap();
        line(2'b10, HOLD);
        line(2'b00, HOLD);
        line(2'b10, HOLD);
        compared++; if (n_esc - b_esc !== 1) begin mismatched++; $display("FAIL esc_err_count: got %0d want 1", n_esc - b_esc); end
        line(2'b00, HOLD);
        line(2'b01, HOLD);
        line(2'b00, HOLD);
        send_byte(8'h1E);
        line(2'b11, HOLD);
        compared++; if ((n_cmd - b_cmd) + (n_vld - b_vld) + (n_ctrl - b_ctrl) !== 0) begin
            mismatched++; $display("FAIL esc_ignored_traffic: got %0d want 0", (n_cmd - b_cmd) + (n_vld - b_vld) + (n_ctrl - b_ctrl)); end
        send_entry();
        send_byte(8'h62);
        line(2'b11, HOLD);
        compared++; if (n_cmd - b_cmd !== 1) begin mismatched++; $display("FAIL esc_reentry_cmd_count: got %0d want 1", n_cmd - b_cmd); end
        compared++; if (last_cmd !== 8'h62) begin mismatched++; $display("FAIL esc_reentry_cmd: got %0h want 62", last_cmd); end
        compared++; if (n_esc - b_esc !== 1) begin mismatched++; $display("FAIL esc_err_total: got %0d want 1", n_esc - b_esc); end
    endtask

    task automatic test_hs_rqst();
        snap();
        line(2'b01, HOLD);
        compared++; if (n_hs - b_hs !== 1) begin mismatched++; $display("FAIL hs_rqst_count: got %0d want 1", n_hs - b_hs); end
        line(2'b00, HOLD);
        line(2'b10, HOLD);
        line(2'b00, HOLD);
        line(2'b01, HOLD);
        line(2'b00, HOLD);
        send_byte(8'hE1);
        send_byte(8'h55);
        line(2'b11, HOLD);
        compared++; if ((n_vld - b_vld) + (n_cmd - b_cmd) + (n_esc - b_esc) + (n_sync - b_sync) !== 0) begin
            mismatched++; $display("FAIL hs_ignored_traffic: got %0d want 0", (n_vld - b_vld) + (n_cmd - b_cmd) + (n_esc - b_esc) + (n_sync - b_sync)); end
        compared++; if (n_act - b_act !== 0) begin mismatched++; $display("FAIL hs_active_cycles: got %0d want 0", n_act - b_act); end
        compared++; if (n_hs - b_hs !== 1) begin mismatched++; $display("FAIL hs_rqst_total: got %0d want 1", n_hs - b_hs); end
    endtask

    task automatic test_ctrl_err();
        snap();
        send_entry();
        send_byte(8'hE1);
        send_bit(1'b1);
        line(2'b10, HOLD);
        line(2'b01, HOLD);
        compared++; if (n_ctrl - b_ctrl !== 1) begin mismatched++; $display("FAIL ctrl_err_count: got %0d want 1", n_ctrl - b_ctrl); end
        compared++; if (rx_active !== 1'b0) begin mismatched++; $display("FAIL ctrl_active: got %b want 0", rx_active); end
        line(2'b11, HOLD);
        compared++; if (n_sync - b_sync !== 0) begin mismatched++; $display("FAIL ctrl_no_sync_err: got %0d want 0", n_sync - b_sync); end
    endtask

    task automatic test_disable();
        snap();
        send_entry();
        send_byte(8'hE1);
        send_bit(1'b1);
        send_bit(1'b1);
        enable = 1'b0;
        repeat (2) @(negedge clk_sys);
        #1;
        compared++; if (rx_active !== 1'b0) begin mismatched++; $display("FAIL disable_active: got %b want 0", rx_active); end
        line(2'b11, HOLD);
        enable = 1'b1;
        line(2'b11, HOLD);
        compared++; if ((n_vld - b_vld) + (n_sync - b_sync) !== 0) begin
            mismatched++; $display("FAIL disable_drop: got %0d want 0", (n_vld - b_vld) + (n_sync - b_sync)); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] outs;
        snap();
        send_entry();
        send_byte(8'hE1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        compared++; if (rx_active !== 1'b1) begin mismatched++; $display("FAIL rstmid_active_before: got %b want 1", rx_active); end
        @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL rstmid_rx_data: got %0h want 00", rx_data); end
        compared++; if (rx_cmd !== 8'h00) begin mismatched++; $display("FAIL rstmid_rx_cmd: got %0h want 00", rx_cmd); end
        outs = {1'b0, rx_valid, rx_cmd_valid, rx_active, rx_hs_rqst, err_esc, err_sync, err_ctrl};
        compared++; if (outs !== 8'h00) begin mismatched++; $display("FAIL rstmid_strobes: got %b want 00000000", outs); end
        line(2'b11, HOLD);
        rst_n = 1'b1;
        line(2'b11, HOLD);
        compared++; if ((n_vld - b_vld) + (n_sync - b_sync) + (n_cmd - b_cmd) !== 0) begin
            mismatched++; $display("FAIL rstmid_no_strobe: got %0d want 0", (n_vld - b_vld) + (n_sync - b_sync) + (n_cmd - b_cmd)); end
        snap();
        send_entry();
        send_byte(8'hE1);
        send_byte(8'h5A);
        line(2'b10, HOLD);
        line(2'b11, HOLD);
        compared++; if (n_vld - b_vld !== 1) begin mismatched++; $display("FAIL rstmid_after_count: got %0d want 1", n_vld - b_vld); end
        compared++; if (rx_data !== 8'h5A) begin mismatched++; $display("FAIL rstmid_after_data: got %0h want 5a", rx_data); end
        compared++; if (n_sync - b_sync !== 0) begin mismatched++; $display("FAIL rstmid_after_sync: got %0d want 0", n_sync - b_sync); end
    endtask

`ifdef DSI_LP_RX_FILTER_EN
    task automatic test_glitch();
        snap();
        send_entry();
        send_byte(8'hE1);
        line(2'b10, 2);
        line(2'b00, HOLD);
        send_byte(8'hA5);
        line(2'b11, HOLD);
        compared++; if (n_vld - b_vld !== 1) begin mismatched++; $display("FAIL glitch_vld_count: got %0d want 1", n_vld - b_vld); end
        compared++; if (rx_data !== 8'hA5) begin mismatched++; $display("FAIL glitch_data: got %0h want a5", rx_data); end
        compared++; if (n_sync - b_sync !== 0) begin mismatched++; $display("FAIL glitch_sync: got %0d want 0", n_sync - b_sync); end
    endtask
`endif

    initial begin
        test_reset();
        test_lpdt();
        test_ulps();
        test_sync_err();
        test_esc_err();
        test_hs_rqst();
        test_ctrl_err();
        test_disable();
`ifdef DSI_LP_RX_FILTER_EN
        test_glitch();
`endif
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
